// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared control bundle, FSM states and hazard constants for the ID/EX stage
package id_ex_stage_pkg;
  localparam logic [4:0] ECALL_ARG_REG = 5'd17;
  typedef enum logic {RUN, HOLD} state_t;
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       is_branch;
    logic       is_ecall;
    logic [3:0] alu_op;
  } ctrl_t;
  localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: combinational load-use and ecall-on-x17 hazard detection
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       id_is_ecall,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_reg_write,
  output logic       lu,
  output logic       ec,
  output logic       ec_load
);
  assign lu = ex_mem_read && ex_rd != 5'd0 &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  assign ec = id_is_ecall && ex_reg_write && ex_rd == ECALL_ARG_REG;
  assign ec_load = ec && ex_mem_read;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with hazard stall FSM and saturating bubble counter
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic            id_alu_src,
  input  logic            id_is_branch,
  input  logic            id_is_ecall,
  input  logic [3:0]      id_alu_op,
  input  logic            flush,
  output logic [XLEN-1:0] id_ex_pc,
  output logic [4:0]      id_ex_rs1,
  output logic [4:0]      id_ex_rs2,
  output logic [4:0]      id_ex_rd,
  output logic [XLEN-1:0] id_ex_rs1_data,
  output logic [XLEN-1:0] id_ex_rs2_data,
  output logic [XLEN-1:0] id_ex_imm,
  output logic            id_ex_reg_write,
  output logic            id_ex_mem_read,
  output logic            id_ex_mem_write,
  output logic            id_ex_mem_to_reg,
  output logic            id_ex_alu_src,
  output logic            id_ex_is_branch,
  output logic            id_ex_is_ecall,
  output logic [3:0]      id_ex_alu_op,
  output logic            pc_write,
  output logic            if_id_write,
  output logic [31:0]     bubble_count
);
  ctrl_t  id_ctrl, ex_ctrl;
  state_t state;
  logic   hold_cnt, lu, ec, ec_load, stall, bubble;
  hazard_detect u_hazard (
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_is_ecall  (id_is_ecall),
    .ex_rd        (id_ex_rd),
    .ex_mem_read  (id_ex_mem_read),
    .ex_reg_write (id_ex_reg_write),
    .lu           (lu),
    .ec           (ec),
    .ec_load      (ec_load)
  );
  assign id_ctrl = '{reg_write: id_reg_write, mem_read: id_mem_read, mem_write: id_mem_write,
                     mem_to_reg: id_mem_to_reg, alu_src: id_alu_src, is_branch: id_is_branch,
                     is_ecall: id_is_ecall, alu_op: id_alu_op};
  assign id_ex_reg_write  = ex_ctrl.reg_write;
  assign id_ex_mem_read   = ex_ctrl.mem_read;
  assign id_ex_mem_write  = ex_ctrl.mem_write;
  assign id_ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign id_ex_alu_src    = ex_ctrl.alu_src;
  assign id_ex_is_branch  = ex_ctrl.is_branch;
  assign id_ex_is_ecall   = ex_ctrl.is_ecall;
  assign id_ex_alu_op     = ex_ctrl.alu_op;
  // reset gating keeps the front end enabled before the ID/EX register is known
  assign stall       = !reset && !flush && (state == HOLD || lu || ec);
  assign bubble      = flush || stall;
  assign pc_write    = !stall;
  assign if_id_write = !stall;
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl        <= CTRL_BUBBLE;
      id_ex_pc       <= '0;
      id_ex_rs1      <= '0;
      id_ex_rs2      <= '0;
      id_ex_rd       <= '0;
      id_ex_rs1_data <= '0;
      id_ex_rs2_data <= '0;
      id_ex_imm      <= '0;
      state          <= RUN;
      hold_cnt       <= 1'b0;
      bubble_count   <= '0;
    end else begin
      ex_ctrl        <= bubble ? CTRL_BUBBLE : id_ctrl;
      id_ex_pc       <= bubble ? '0 : id_pc;
      id_ex_rs1      <= bubble ? '0 : id_rs1;
      id_ex_rs2      <= bubble ? '0 : id_rs2;
      id_ex_rd       <= bubble ? '0 : id_rd;
      id_ex_rs1_data <= bubble ? '0 : id_rs1_data;
      id_ex_rs2_data <= bubble ? '0 : id_rs2_data;
      id_ex_imm      <= bubble ? '0 : id_imm;
      if (bubble && !(&bubble_count)) bubble_count <= bubble_count + 32'd1;
      if (flush) state <= RUN;
      else if (state == RUN && ec_load) begin
        state    <= HOLD;
        hold_cnt <= 1'b0;
      end else if (state == HOLD) begin
        state    <= hold_cnt ? HOLD : RUN;
        hold_cnt <= hold_cnt ? hold_cnt - 1'b1 : 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for the ID/EX stage hazard and bubble behaviour
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, id_mem_write;
  logic        id_mem_to_reg, id_alu_src, id_is_branch, id_is_ecall, flush;
  logic [3:0]  id_alu_op;
  logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, bubble_count;
  logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg;
  logic        id_ex_alu_src, id_ex_is_branch, id_ex_is_ecall, pc_write, if_id_write;
  logic [3:0]  id_ex_alu_op;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_alu_src(id_alu_src), .id_is_branch(id_is_branch), .id_is_ecall(id_is_ecall),
    .id_alu_op(id_alu_op), .flush(flush),
    .id_ex_pc(id_ex_pc), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data), .id_ex_imm(id_ex_imm),
    .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_mem_write(id_ex_mem_write), .id_ex_mem_to_reg(id_ex_mem_to_reg),
    .id_ex_alu_src(id_ex_alu_src), .id_ex_is_branch(id_ex_is_branch),
    .id_ex_is_ecall(id_ex_is_ecall), .id_ex_alu_op(id_ex_alu_op),
    .pc_write(pc_write), .if_id_write(if_id_write), .bubble_count(bubble_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // data fields are derived from pc so registered copies are easy to predict
  task automatic ins(input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                     input logic u1, u2, rw, mr, ec);
    id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_use_rs1 = u1; id_use_rs2 = u2; id_reg_write = rw; id_mem_read = mr;
    id_mem_to_reg = mr; id_alu_src = mr; id_is_ecall = ec;
    id_mem_write = 1'b0; id_is_branch = 1'b0; id_alu_op = 4'h3;
    id_rs1_data = pc + 32'd1; id_rs2_data = pc + 32'd2; id_imm = pc + 32'd3;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    ins(32'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    #1;
    chk("pc_write_in_reset", {31'd0, pc_write}, 32'd1);
    tick(); tick();
    chk("reset_rd", {27'd0, id_ex_rd}, 32'd0);
    chk("reset_pc", id_ex_pc, 32'd0);
    chk("reset_count", bubble_count, 32'd0);
    reset = 1'b0;
    // load-use: lw x5 then add x6,x5,x7
    ins(32'h100, 5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 0);
    #1 chk("lw_no_stall", {31'd0, pc_write}, 32'd1);
    tick();
    chk("lw_mem_read", {31'd0, id_ex_mem_read}, 32'd1);
    chk("lw_rd", {27'd0, id_ex_rd}, 32'd5);
    ins(32'h104, 5'd5, 5'd7, 5'd6, 1, 1, 1, 0, 0);
    #1 chk("lu_pc_write", {31'd0, pc_write}, 32'd0);
    chk("lu_if_id_write", {31'd0, if_id_write}, 32'd0);
    tick();
    chk("lu_bubble_rd", {27'd0, id_ex_rd}, 32'd0);
    chk("lu_bubble_alu_op", {28'd0, id_ex_alu_op}, 32'd0);
    chk("lu_count", bubble_count, 32'd1);
    #1 chk("lu_release", {31'd0, pc_write}, 32'd1);
    tick();
    chk("add_rd", {27'd0, id_ex_rd}, 32'd6);
    chk("add_rs1", {27'd0, id_ex_rs1}, 32'd5);
    chk("add_rs2_data", id_ex_rs2_data, 32'h106);
    chk("add_pc", id_ex_pc, 32'h104);
    // addi x17 then ecall: one bubble
    ins(32'h108, 5'd0, 5'd0, 5'd17, 1, 0, 1, 0, 0);
    tick();
    ins(32'h10c, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    #1 chk("ec_alu_stall", {31'd0, pc_write}, 32'd0);
    tick();
    chk("ec_alu_bubble", {31'd0, id_ex_is_ecall}, 32'd0);
    chk("ec_alu_count", bubble_count, 32'd2);
    #1 chk("ec_alu_release", {31'd0, pc_write}, 32'd1);
    tick();
    chk("ec_alu_ecall", {31'd0, id_ex_is_ecall}, 32'd1);
    chk("ec_alu_pc", id_ex_pc, 32'h10c);
    // lw x17 then ecall: two bubbles
    ins(32'h110, 5'd2, 5'd0, 5'd17, 1, 0, 1, 1, 0);
    tick();
    ins(32'h114, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    #1 chk("ec_ld_stall1", {31'd0, pc_write}, 32'd0);
    tick();
    chk("ec_ld_count1", bubble_count, 32'd3);
    #1 chk("ec_ld_hold", {31'd0, pc_write}, 32'd0);
    tick();
    chk("ec_ld_count2", bubble_count, 32'd4);
    chk("ec_ld_bubble", {31'd0, id_ex_is_ecall}, 32'd0);
    #1 chk("ec_ld_release", {31'd0, if_id_write}, 32'd1);
    tick();
    chk("ec_ld_ecall", {31'd0, id_ex_is_ecall}, 32'd1);
    chk("ec_ld_pc", id_ex_pc, 32'h114);
    // flush overrides a load-use stall
    ins(32'h118, 5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 0);
    tick();
    ins(32'h11c, 5'd5, 5'd7, 5'd6, 1, 1, 1, 0, 0);
    flush = 1'b1;
    #1 chk("flush_pc_write", {31'd0, pc_write}, 32'd1);
    tick();
    flush = 1'b0;
    chk("flush_rd", {27'd0, id_ex_rd}, 32'd0);
    chk("flush_pc", id_ex_pc, 32'd0);
    chk("flush_count", bubble_count, 32'd5);
    #1 chk("flush_run", {31'd0, pc_write}, 32'd1);
    tick();
    chk("post_flush_pc", id_ex_pc, 32'h11c);
    // reset during HOLD
    ins(32'h120, 5'd2, 5'd0, 5'd17, 1, 0, 1, 1, 0);
    tick();
    ins(32'h124, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    tick();
    chk("hold_count", bubble_count, 32'd6);
    #1 chk("hold_stall", {31'd0, pc_write}, 32'd0);
    reset = 1'b1;
    #1 chk("hold_reset_pc_write", {31'd0, pc_write}, 32'd1);
    tick();
    reset = 1'b0;
    chk("hold_reset_count", bubble_count, 32'd0);
    chk("hold_reset_pc", id_ex_pc, 32'd0);
    #1 chk("hold_reset_run", {31'd0, pc_write}, 32'd1);
    tick();
    chk("hold_reset_ecall", {31'd0, id_ex_is_ecall}, 32'd1);
    // x0 destination never stalls
    ins(32'h130, 5'd2, 5'd0, 5'd0, 1, 0, 1, 1, 0);
    tick();
    ins(32'h134, 5'd0, 5'd0, 5'd1, 1, 1, 1, 0, 0);
    #1 chk("x0_no_stall", {31'd0, pc_write}, 32'd1);
    tick();
    chk("x0_rd", {27'd0, id_ex_rd}, 32'd1);
    chk("x0_pc", id_ex_pc, 32'h134);
    chk("x0_count", bubble_count, 32'd0);
    // rs2 match honours use_rs2
    ins(32'h138, 5'd2, 5'd0, 5'd9, 1, 0, 1, 1, 0);
    tick();
    ins(32'h13c, 5'd3, 5'd9, 5'd4, 1, 0, 1, 0, 0);
    #1 chk("rs2_unused_no_stall", {31'd0, pc_write}, 32'd1);
    id_use_rs2 = 1'b1;
    #1 chk("rs2_used_stall", {31'd0, pc_write}, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
